// File: rtl/adc_axis_capture.sv
// Generic synchronous FIFO with registered storage; read data is the head entry.
// Latency: a write is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: caller gates writes on full (or full with a same-cycle read) and reads on empty.
module adc_axis_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_vld ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_rdy ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// ADC word stream capture with decimation into fixed-length AXI4-Stream frames.
// Latency: a sample accepted in cycle c is presented on axis_tvalid in cycle c+2.
// Backpressure: FIFO plus output register absorb stalls; kept samples arriving while full are dropped.
module adc_axis_capture #(
    parameter int  NUM_CH     = 2,
    parameter int  SAMPLE_W   = 8,
    parameter int  FRAME_LEN  = 1024,
    parameter int  FIFO_DEPTH = 16,
    parameter int  WARMUP_CYC = 64,
    localparam int DATA_W     = NUM_CH * SAMPLE_W,
    localparam int TDATA_W    = 8 * ((DATA_W + 7) / 8)
) (
    input  logic                 axis_aclk,
    input  logic                 axis_aresetn,
    input  logic                 adc_valid,
    input  logic [DATA_W-1:0]    adc_data,
    output logic                 adc_pdn,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_mode,
    input  logic [7:0]           cfg_decim,
    output logic                 axis_tvalid,
    input  logic                 axis_tready,
    output logic [TDATA_W-1:0]   axis_tdata,
    output logic [TDATA_W/8-1:0] axis_tkeep,
    output logic                 axis_tlast,
    output logic                 stat_busy,
    output logic                 stat_overflow,
    output logic [15:0]          stat_frames
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WARMUP  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam int          WARM_W    = $clog2(WARMUP_CYC + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
    localparam logic [15:0] LAST_IDX  = 16'(FRAME_LEN - 1);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] dat;
    } beat_t;

    logic [1:0]         state_q, state_d;
    logic               pdn_q, pdn_d;
    logic               mode_q, mode_d;
    logic [7:0]         decim_q, decim_d;
    logic [7:0]         decim_cnt_q, decim_cnt_d;
    logic [15:0]        sample_cnt_q, sample_cnt_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic               stop_q, stop_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        frames_q, frames_d;
    logic               out_vld_q, out_vld_d;
    logic               out_last_q, out_last_d;
    logic [TDATA_W-1:0] out_dat_q, out_dat_d;

    logic  fifo_wr_vld, fifo_rd_rdy, fifo_empty, fifo_full;
    beat_t fifo_wr_dat, fifo_rd_dat;
    logic  hs, kept;

    adc_axis_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (axis_aclk),
        .rst_n  (axis_aresetn),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (fifo_rd_rdy),
        .rd_dat (fifo_rd_dat),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        decim_d      = decim_q;
        decim_cnt_d  = decim_cnt_q;
        sample_cnt_d = sample_cnt_q;
        warm_cnt_d   = warm_cnt_q;
        stop_d       = stop_q;
        ovf_d        = ovf_q;
        frames_d     = frames_q;
        out_vld_d    = out_vld_q;
        out_last_d   = out_last_q;
        out_dat_d    = out_dat_q;
        kept         = 1'b0;
        fifo_wr_vld  = 1'b0;
        fifo_wr_dat  = '{last: (sample_cnt_q == LAST_IDX), dat: adc_data};
        hs           = out_vld_q && axis_tready;
        fifo_rd_rdy  = !fifo_empty && (!out_vld_q || axis_tready);

        if (hs && out_last_q) frames_d = frames_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (cfg_start) begin
                    mode_d       = cfg_mode;
                    decim_d      = cfg_decim;
                    ovf_d        = 1'b0;
                    sample_cnt_d = '0;
                    decim_cnt_d  = '0;
                    warm_cnt_d   = '0;
                    state_d      = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_LAST) state_d = ST_CAPTURE;
                else warm_cnt_d = warm_cnt_q + 1'b1;
            end
            ST_CAPTURE: begin
                if (cfg_stop) stop_d = 1'b1;
                if (adc_valid) begin
                    kept        = (decim_cnt_q == 8'd0);
                    decim_cnt_d = (decim_cnt_q == decim_q) ? 8'd0 : decim_cnt_q + 8'd1;
                end
                // A same-cycle read frees a slot, so a full FIFO still accepts the write.
                if (kept) begin
                    if (fifo_full && !fifo_rd_rdy) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_wr_vld = 1'b1;
                        if (fifo_wr_dat.last) begin
                            sample_cnt_d = '0;
                            if (!mode_q || stop_q || cfg_stop) state_d = ST_DRAIN;
                        end else begin
                            sample_cnt_d = sample_cnt_q + 16'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // With no further writes, a tagged beat leaving an empty FIFO is the final one.
                if (hs && out_last_q && fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pdn_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);

        if (fifo_rd_rdy) begin
            out_vld_d  = 1'b1;
            out_last_d = fifo_rd_dat.last;
            out_dat_d  = TDATA_W'(fifo_rd_dat.dat);
        end else if (hs) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= ST_IDLE;
            pdn_q        <= 1'b1;
            mode_q       <= 1'b0;
            decim_q      <= '0;
            decim_cnt_q  <= '0;
            sample_cnt_q <= '0;
            warm_cnt_q   <= '0;
            stop_q       <= 1'b0;
            ovf_q        <= 1'b0;
            frames_q     <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_dat_q    <= '0;
        end else begin
            state_q      <= state_d;
            pdn_q        <= pdn_d;
            mode_q       <= mode_d;
            decim_q      <= decim_d;
            decim_cnt_q  <= decim_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            stop_q       <= stop_d;
            ovf_q        <= ovf_d;
            frames_q     <= frames_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            out_dat_q    <= out_dat_d;
        end
    end

    assign adc_pdn       = pdn_q;
    assign axis_tvalid   = out_vld_q;
    assign axis_tdata    = out_dat_q;
    assign axis_tlast    = out_last_q;
    assign axis_tkeep    = {(TDATA_W/8){out_vld_q}};
    assign stat_busy     = (state_q != ST_IDLE);
    assign stat_overflow = ovf_q;
    assign stat_frames   = frames_q;
endmodule

// File: tb/tb_adc_axis_capture.sv
// Directed bench for adc_axis_capture: 2 channels x 8 bits, 8-beat frames, 4-cycle warmup.
module tb_adc_axis_capture;
    localparam int W  = 4;
    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        axis_aresetn;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        adc_pdn;
    logic        cfg_start, cfg_stop, cfg_mode;
    logic [7:0]  cfg_decim;
    logic        axis_tvalid, axis_tready, axis_tlast;
    logic [15:0] axis_tdata;
    logic [1:0]  axis_tkeep;
    logic        stat_busy, stat_overflow;
    logic [15:0] stat_frames;

    adc_axis_capture #(
        .NUM_CH     (2),
        .SAMPLE_W   (8),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (16),
        .WARMUP_CYC (W)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (axis_aresetn),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .adc_pdn       (adc_pdn),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_mode      (cfg_mode),
        .cfg_decim     (cfg_decim),
        .axis_tvalid   (axis_tvalid),
        .axis_tready   (axis_tready),
        .axis_tdata    (axis_tdata),
        .axis_tkeep    (axis_tkeep),
        .axis_tlast    (axis_tlast),
        .stat_busy     (stat_busy),
        .stat_overflow (stat_overflow),
        .stat_frames   (stat_frames)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] ramp;

    logic [15:0] q_dat[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic [15:0] e_dat[$];
    logic        e_last[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beats recorded mid-cycle; they are handshaken on the following rising edge.
    always @(negedge clk) begin
        if (axis_tvalid && axis_tready) begin
            q_dat.push_back(axis_tdata);
            q_last.push_back(axis_tlast);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] samp(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b + 8'h80, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        ramp     = ramp + 8'd1;
        adc_data = {ramp + 8'h80, ramp};
    endtask

    // Ramp is aligned so the first CAPTURE cycle presents sample value 0.
    task automatic start(input logic mode, input logic [7:0] decim);
        cfg_mode  = mode;
        cfg_decim = decim;
        cfg_start = 1'b1;
        ramp      = 8'(256 - (W + 1));
        adc_data  = {ramp + 8'h80, ramp};
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic clear_q();
        q_dat.delete();
        q_last.delete();
        q_cyc.delete();
        e_dat.delete();
        e_last.delete();
    endtask

    task automatic check_beats(input string name, input int spacing);
        chk($sformatf("%s beat count", name), q_dat.size(), e_dat.size());
        for (int i = 0; i < e_dat.size(); i++) begin
            if (i < q_dat.size()) begin
                chk($sformatf("%s tdata[%0d]", name, i), q_dat[i], e_dat[i]);
                chk($sformatf("%s tlast[%0d]", name, i), q_last[i], e_last[i]);
                if (i > 0 && spacing > 0)
                    chk($sformatf("%s spacing[%0d]", name, i), q_cyc[i] - q_cyc[i-1], spacing);
            end
        end
    endtask

    initial begin
        axis_aresetn = 1'b0;
        adc_valid    = 1'b1;
        ramp         = 8'd0;
        adc_data     = 16'h8000;
        cfg_start    = 1'b0;
        cfg_stop     = 1'b0;
        cfg_mode     = 1'b0;
        cfg_decim    = 8'd0;
        axis_tready  = 1'b1;
        repeat (3) tick();

        chk("rst adc_pdn", adc_pdn, 1);
        chk("rst tvalid", axis_tvalid, 0);
        chk("rst tdata", axis_tdata, 0);
        chk("rst tkeep", axis_tkeep, 0);
        chk("rst tlast", axis_tlast, 0);
        chk("rst busy", stat_busy, 0);
        chk("rst overflow", stat_overflow, 0);
        chk("rst frames", stat_frames, 0);
        axis_aresetn = 1'b1;
        tick();
        clear_q();

        // Single-shot ramp with latency checks and an ignored mid-capture start.
        chk("t1 pdn before start", adc_pdn, 1);
        start(1'b0, 8'd0);
        chk("t1 pdn after start", adc_pdn, 0);
        chk("t1 busy after start", stat_busy, 1);
        repeat (W + 1) tick();
        chk("t1 tvalid at c+1", axis_tvalid, 0);
        tick();
        chk("t1 tvalid at c+2", axis_tvalid, 1);
        chk("t1 first tdata", axis_tdata, samp(0));
        chk("t1 tkeep", axis_tkeep, 2'b11);
        chk("t1 first tlast", axis_tlast, 0);
        cfg_start = 1'b1;
        cfg_mode  = 1'b1;
        cfg_decim = 8'd3;
        tick();
        cfg_start = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < FL; i++) begin
            e_dat.push_back(samp(i));
            e_last.push_back(i == FL - 1);
        end
        check_beats("t1", 1);
        chk("t1 frames", stat_frames, 1);
        chk("t1 pdn end", adc_pdn, 1);
        chk("t1 busy end", stat_busy, 0);
        chk("t1 overflow", stat_overflow, 0);
        clear_q();

        // Decimation by 4.
        start(1'b0, 8'd3);
        repeat (45) tick();
        for (int i = 0; i < FL; i++) begin
            e_dat.push_back(samp(4 * i));
            e_last.push_back(i == FL - 1);
        end
        check_beats("t2", 4);
        chk("t2 frames", stat_frames, 2);
        chk("t2 busy end", stat_busy, 0);
        clear_q();

        // Continuous mode held off by tready=0 long enough to overflow.
        axis_tready = 1'b0;
        start(1'b1, 8'd0);
        repeat (W) tick();
        repeat (5) tick();
        chk("t3 stall tvalid", axis_tvalid, 1);
        chk("t3 stall tdata", axis_tdata, samp(0));
        repeat (5) tick();
        chk("t3 overflow early", stat_overflow, 0);
        repeat (10) tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        repeat (18) tick();
        chk("t3 stall tvalid held", axis_tvalid, 1);
        chk("t3 stall tdata held", axis_tdata, samp(0));
        chk("t3 stall tlast held", axis_tlast, 0);
        chk("t3 overflow set", stat_overflow, 1);
        chk("t3 busy stalled", stat_busy, 1);
        tick();
        axis_tready = 1'b1;
        repeat (60) tick();
        for (int i = 0; i < 24; i++) begin
            e_dat.push_back(samp(i <= 16 ? i : i + 23));
            e_last.push_back((i % FL) == FL - 1);
        end
        check_beats("t3", 0);
        chk("t3 frames", stat_frames, 5);
        chk("t3 busy end", stat_busy, 0);
        clear_q();

        // Continuous mode stopped in the middle of frame 2.
        start(1'b1, 8'd0);
        repeat (W) tick();
        repeat (11) tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        repeat (25) tick();
        for (int i = 0; i < 2 * FL; i++) begin
            e_dat.push_back(samp(i));
            e_last.push_back((i % FL) == FL - 1);
        end
        check_beats("t4", 1);
        chk("t4 frames", stat_frames, 7);
        chk("t4 busy end", stat_busy, 0);
        chk("t4 pdn end", adc_pdn, 1);
        chk("t4 overflow", stat_overflow, 0);
        clear_q();

        // Reset asserted mid-frame, then a clean restart.
        start(1'b0, 8'd0);
        repeat (W + 4) tick();
        chk("t5 tvalid before reset", axis_tvalid, 1);
        axis_aresetn = 1'b0;
        #1;
        chk("t5 rst tvalid", axis_tvalid, 0);
        chk("t5 rst tdata", axis_tdata, 0);
        chk("t5 rst tkeep", axis_tkeep, 0);
        chk("t5 rst tlast", axis_tlast, 0);
        chk("t5 rst pdn", adc_pdn, 1);
        chk("t5 rst busy", stat_busy, 0);
        chk("t5 rst frames", stat_frames, 0);
        repeat (2) tick();
        axis_aresetn = 1'b1;
        tick();
        clear_q();
        start(1'b0, 8'd0);
        repeat (W + 15) tick();
        for (int i = 0; i < FL; i++) begin
            e_dat.push_back(samp(i));
            e_last.push_back(i == FL - 1);
        end
        check_beats("t5", 1);
        chk("t5 frames", stat_frames, 1);
        chk("t5 busy end", stat_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_axis_capture.md
# adc_axis_capture

Parametrised ADC-to-AXI4-Stream capture engine, the next generation of the team's ADC stream blocks. Samples a multi-channel ADC word stream that is already synchronous to the AXI clock, with optional decimation, into an internal FIFO. It emits fixed-length frames on an AXI4-Stream master, with `tlast` on the final beat, in either single-shot or continuous mode. It sits between the ADC input capture and the DMA/stream interconnect, and also drives the ADC power-down pin.

## Interface
Parameters:
- `NUM_CH`, default 2: number of ADC channels packed per beat (1..8).
- `SAMPLE_W`, default 8: bits per channel sample (1..16).
- `FRAME_LEN`, default 1024: beats per frame (2..65535).
- `FIFO_DEPTH`, default 16: FIFO entries (power of 2, ≥4).
- `WARMUP_CYC`, default 64: cycles between `adc_pdn` deasserting and the first accepted sample (≥1).
- Derived `TDATA_W` = 8·ceil(NUM_CH·SAMPLE_W/8).

Ports:
- `axis_aclk`, in, 1: the single clock; all logic is on its rising edge.
- `axis_aresetn`, in, 1: asynchronous, active-low reset.
- `adc_valid`, in, 1: `adc_data` holds a new sample this cycle.
- `adc_data`, in, NUM_CH·SAMPLE_W: channel k occupies bits [k·SAMPLE_W +: SAMPLE_W].
- `adc_pdn`, out, 1: ADC power-down, high means powered down.
- `cfg_start`, in, 1: one-cycle pulse that starts a capture. Ignored unless in IDLE.
- `cfg_stop`, in, 1: one-cycle pulse that ends continuous mode at the next frame boundary.
- `cfg_mode`, in, 1: 0 = single frame, 1 = continuous. Sampled on `cfg_start`.
- `cfg_decim`, in, 8: keep 1 of every `cfg_decim`+1 valid samples. Sampled on `cfg_start`.
- `axis_tvalid`, out, 1; `axis_tready`, in, 1: AXI4-Stream handshake.
- `axis_tdata`, out, TDATA_W: channel samples packed from the LSB, pad bits 0.
- `axis_tkeep`, out, TDATA_W/8: all ones whenever `axis_tvalid` is high, otherwise 0.
- `axis_tlast`, out, 1: marks the final beat of a frame.
- `stat_busy`, out, 1: high when the FSM is not in IDLE.
- `stat_overflow`, out, 1: sticky, set when a sample is dropped because the FIFO is full.
- `stat_frames`, out, 16: count of frames completed on the stream (last beat handshaken). Wraps at 2^16.

## Operation
Reset values: `adc_pdn`=1; `axis_tvalid`, `axis_tlast`, `axis_tkeep`, `axis_tdata`=0; `stat_*`=0; FSM in IDLE; FIFO empty.

FSM states:
- IDLE: `adc_pdn`=1. `cfg_start` latches mode and decim, clears `stat_overflow`, clears the sample and decimation counters, then goes to WARMUP.
- WARMUP: `adc_pdn`=0. Counts WARMUP_CYC cycles, then goes to CAPTURE. Samples are not accepted here.
- CAPTURE: `adc_pdn`=0. A sample is "kept" when `adc_valid`=1 and the decimation counter is 0.
  - The decimation counter runs 0..cfg_decim on each `adc_valid` and wraps to 0.
  - A kept sample with FIFO not full is written with a last-tag = (sample_cnt == FRAME_LEN−1).
  - sample_cnt increments on each write and wraps to 0 after the tagged write.
  - A kept sample with FIFO full is dropped, sets `stat_overflow`, and does not advance sample_cnt. Frames therefore always contain exactly FRAME_LEN beats.
  - On the tagged write: in single mode, or in continuous mode with a stop pending, go to DRAIN. Otherwise stay in CAPTURE.
- DRAIN: `adc_pdn`=1. No writes. Returns to IDLE on the cycle after the tagged beat is handshaken.
- A `cfg_stop` seen at any time in CAPTURE sets stop-pending, which is cleared in IDLE. `cfg_stop` in other states is ignored.
- `cfg_start` outside IDLE is ignored.

Output stage:
- A registered output holds one beat. It loads from the FIFO when empty, or when `axis_tvalid` && `axis_tready`.
- `axis_tlast` carries the stored last-tag. `axis_tdata`/`axis_tlast` are stable while `tvalid` && !`tready`.
- Beats are never dropped or duplicated after the FIFO write.
- FIFO plus output register hold FIFO_DEPTH+1 beats.

Simultaneous events:
- A FIFO read and write in the same cycle when full: the write succeeds.
- Write and read when empty: data passes through, with no bypass of the output register.

`axis_aresetn` low mid-frame: immediate return to reset values. The FIFO contents and the partial frame are discarded, and there is no `tlast` flush.

## Timing
- Sample accepted at the edge ending cycle c → earliest `axis_tvalid` with that beat in cycle c+2.
- After `cfg_start` in cycle c: `adc_pdn` falls in c+1. The first sample can be accepted in cycle c+1+WARMUP_CYC.
- Sustained throughput is 1 beat/cycle with `axis_tready`=1 and `adc_valid`=1, `cfg_decim`=0. No bubbles at frame boundaries in continuous mode.
- `stat_frames` increments on the edge that handshakes a `tlast` beat.
- `stat_busy` falls with the DRAIN→IDLE transition.

## Test plan
- Single-shot, NUM_CH=2, SAMPLE_W=8, FRAME_LEN=8, decim 0, `tready`=1, ramp input {ch1=i+0x80, ch0=i} → 8 beats `tdata`=0x8000+0x0101·i (i=0..7); `tlast` only on i=7; `stat_frames`=1; `adc_pdn` returns to 1.
- Decimation 3, `adc_valid` every cycle, ramp input → output ch0 = 0,4,8,…; beat spacing 4 cycles.
- Backpressure: `tready`=0 for 40 cycles, FIFO_DEPTH=16 → `stat_overflow`=1; every frame still has exactly FRAME_LEN beats; `tdata` held stable while stalled.
- Continuous mode with `cfg_stop` mid-frame 2 → frames 1–2 complete, `tlast` every 8th beat with no gap, then DRAIN/IDLE; `stat_frames`=2.
- `cfg_start` during CAPTURE is ignored. `axis_aresetn` pulsed low mid-frame → all outputs at reset values within the reset cycle; a new start afterwards produces a clean frame starting at sample 0.
- Latency check: first accepted sample in cycle c gives `tvalid` in c+2. `adc_pdn` low for WARMUP_CYC cycles before the first accept.
